// File: rtl/floating_point_divider_if.sv
// ---------------------------------------------------------------------------
// floating_point_divider_if
//
// Groups the operand and result handshakes of the floating-point divider.
//   in_valid / in_ready   : operand handshake (a, b accepted when both high)
//   a, b                  : dividend and divisor
//   out_valid / out_ready : result handshake
//   out                   : quotient
//   underflow_flag, overflow_flag, invalid_operation_flag, divide_by_zero_flag
//                         : result flags, meaningful only while out_valid=1
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the divider itself
// ---------------------------------------------------------------------------
interface floating_point_divider_if #(
  parameter int ExponentWidth = 8,
  parameter int MantissaWidth = 23
);
  localparam int FloatBitWidth = ExponentWidth + MantissaWidth + 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [FloatBitWidth-1:0] a;
  logic [FloatBitWidth-1:0] b;
  logic                     out_valid;
  logic                     out_ready;
  logic [FloatBitWidth-1:0] out;
  logic                     underflow_flag;
  logic                     overflow_flag;
  logic                     invalid_operation_flag;
  logic                     divide_by_zero_flag;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out,
    input  underflow_flag, overflow_flag, invalid_operation_flag, divide_by_zero_flag
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out,
    output underflow_flag, overflow_flag, invalid_operation_flag, divide_by_zero_flag
  );
endinterface

// File: rtl/floating_point_divider.sv
// ---------------------------------------------------------------------------
// floating_point_divider
//
// Sequential IEEE-754-style divider, out = a / b. Restoring division retires
// one quotient bit per cycle, followed by a single normalise + round-to-
// nearest-even cycle. Special operands bypass the divider and produce their
// result one edge after acceptance. Denormal inputs are read as signed zero
// and results never become denormal (they flush to zero).
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low; discards any operation in flight
//   bus   : floating_point_divider_if.slave
//           in_valid/in_ready, a, b           - operand handshake
//           out_valid/out_ready, out, flags   - result handshake (stallable)
// ---------------------------------------------------------------------------
module floating_point_divider #(
  parameter int ExponentWidth = 8,
  parameter int MantissaWidth = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  floating_point_divider_if.slave bus
);

  localparam int FloatBitWidth = ExponentWidth + MantissaWidth + 1;
  // integer bit + fraction + guard + round, plus one spare so that a
  // quotient below 1.0 still has a full-precision significand after the
  // normalising left shift.
  localparam int QuotWidth     = MantissaWidth + 4;
  localparam int ExpCalcWidth  = ExponentWidth + 2;
  localparam int CountWidth    = $clog2(QuotWidth + 1);
  localparam int BiasInt       = (1 << (ExponentWidth - 1)) - 1;
  localparam int ExpMaxInt     = (1 << ExponentWidth) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_ROUND,
    ST_SPECIAL,
    ST_DONE
  } state_t;

  // Zero/denormal exponent or all-ones exponent on either side means the
  // quotient is decided without dividing.
  function automatic logic is_special(input logic [FloatBitWidth-1:0] x,
                                      input logic [FloatBitWidth-1:0] y);
    logic [ExponentWidth-1:0] ex;
    logic [ExponentWidth-1:0] ey;
    ex = x[FloatBitWidth-2 -: ExponentWidth];
    ey = y[FloatBitWidth-2 -: ExponentWidth];
    return (ex == '0) || (&ex) || (ey == '0) || (&ey);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic [FloatBitWidth-1:0]  a_q, a_d;
  logic [FloatBitWidth-1:0]  b_q, b_d;
  logic [MantissaWidth+1:0]  rem_q, rem_d;
  logic [MantissaWidth:0]    div_q, div_d;
  logic [QuotWidth-1:0]      quot_q, quot_d;
  logic [CountWidth-1:0]     count_q, count_d;
  logic [FloatBitWidth-1:0]  out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      underflow_flag_q, underflow_flag_d;
  logic                      overflow_flag_q, overflow_flag_d;
  logic                      invalid_flag_q, invalid_flag_d;
  logic                      dbz_flag_q, dbz_flag_d;

  // -------------------------------------------------------------------------
  // Field decode of the latched operands
  // -------------------------------------------------------------------------
  logic                     sign_a, sign_b, res_sign;
  logic [ExponentWidth-1:0] exp_a, exp_b;
  logic [MantissaWidth-1:0] frac_a, frac_b;
  logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    sign_a   = a_q[FloatBitWidth-1];
    sign_b   = b_q[FloatBitWidth-1];
    exp_a    = a_q[FloatBitWidth-2 -: ExponentWidth];
    exp_b    = b_q[FloatBitWidth-2 -: ExponentWidth];
    frac_a   = a_q[MantissaWidth-1:0];
    frac_b   = b_q[MantissaWidth-1:0];
    res_sign = sign_a ^ sign_b;
    a_zero   = (exp_a == '0);
    b_zero   = (exp_b == '0);
    a_inf    = (&exp_a) && (frac_a == '0);
    b_inf    = (&exp_b) && (frac_b == '0);
    a_nan    = (&exp_a) && (frac_a != '0);
    b_nan    = (&exp_b) && (frac_b != '0);
  end

  // -------------------------------------------------------------------------
  // Special-value result, in priority order
  // -------------------------------------------------------------------------
  logic [FloatBitWidth-1:0] sp_out;
  logic                     sp_uf, sp_of, sp_inv, sp_dbz;

  always_comb begin
    sp_out = '0;
    sp_uf  = 1'b0;
    sp_of  = 1'b0;
    sp_inv = 1'b0;
    sp_dbz = 1'b0;
    if (a_nan) begin
      // NaN keeps the sign of the first NaN operand and is quietened to the
      // canonical payload.
      sp_out = {sign_a, {ExponentWidth{1'b1}}, 1'b1, {(MantissaWidth-1){1'b0}}};
      sp_inv = 1'b1;
    end else if (b_nan) begin
      sp_out = {sign_b, {ExponentWidth{1'b1}}, 1'b1, {(MantissaWidth-1){1'b0}}};
      sp_inv = 1'b1;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_out = {1'b0, {ExponentWidth{1'b1}}, 1'b1, {(MantissaWidth-1){1'b0}}};
      sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_out = {res_sign, {ExponentWidth{1'b1}}, {MantissaWidth{1'b0}}};
      sp_of  = 1'b1;
    end else if (b_zero) begin
      sp_out = {res_sign, {ExponentWidth{1'b1}}, {MantissaWidth{1'b0}}};
      sp_dbz = 1'b1;
    end else begin
      // 0 / finite or finite / inf
      sp_out = {res_sign, {(FloatBitWidth-1){1'b0}}};
    end
  end

  // -------------------------------------------------------------------------
  // Restoring division step
  // -------------------------------------------------------------------------
  logic [MantissaWidth+1:0] rem_diff;
  logic                     rem_ge;
  logic [MantissaWidth+1:0] rem_step;

  always_comb begin
    rem_ge   = (rem_q >= {1'b0, div_q});
    rem_diff = rem_q - {1'b0, div_q};
    // The partial remainder is always below the divisor after the restore,
    // so doubling it never loses the top bit.
    rem_step = rem_ge ? {rem_diff[MantissaWidth:0], 1'b0}
                      : {rem_q[MantissaWidth:0], 1'b0};
  end

  // -------------------------------------------------------------------------
  // Normalise and round (RNE)
  // -------------------------------------------------------------------------
  logic                            norm;
  logic [MantissaWidth-1:0]        frac_pre;
  logic                            guard_bit, sticky_bit, round_up;
  logic [MantissaWidth-1:0]        frac_rnd;
  logic                            rnd_carry;
  logic signed [ExpCalcWidth-1:0]  exp_calc;
  logic [FloatBitWidth-1:0]        rnd_out;
  logic                            rnd_uf, rnd_of;

  always_comb begin
    // Quotient of two [1,2) significands lies in (0.5, 2): a clear integer
    // bit means one left shift is needed.
    norm       = ~quot_q[QuotWidth-1];
    frac_pre   = norm ? quot_q[QuotWidth-3:2] : quot_q[QuotWidth-2:3];
    guard_bit  = norm ? quot_q[1] : quot_q[2];
    sticky_bit = (norm ? quot_q[0] : (|quot_q[1:0])) | (|rem_q);
    round_up   = guard_bit & (sticky_bit | frac_pre[0]);
    // A carry out of the fraction means the significand rounded up to 2.0:
    // the fraction is already all zeros, only the exponent moves.
    {rnd_carry, frac_rnd} = {1'b0, frac_pre} + {{MantissaWidth{1'b0}}, round_up};
    exp_calc   = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
               + $signed(ExpCalcWidth'(BiasInt))
               - $signed(ExpCalcWidth'(norm))
               + $signed(ExpCalcWidth'(rnd_carry));
    rnd_uf  = 1'b0;
    rnd_of  = 1'b0;
    rnd_out = {res_sign, exp_calc[ExponentWidth-1:0], frac_rnd};
    if (exp_calc >= $signed(ExpCalcWidth'(ExpMaxInt))) begin
      rnd_out = {res_sign, {ExponentWidth{1'b1}}, {MantissaWidth{1'b0}}};
      rnd_of  = 1'b1;
    end else if (exp_calc[ExpCalcWidth-1] || (exp_calc == '0)) begin
      rnd_out = {res_sign, {(FloatBitWidth-1){1'b0}}};
      rnd_uf  = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    a_d              = a_q;
    b_d              = b_q;
    rem_d            = rem_q;
    div_d            = div_q;
    quot_d           = quot_q;
    count_d          = count_q;
    out_d            = out_q;
    out_valid_d      = out_valid_q;
    underflow_flag_d = underflow_flag_q;
    overflow_flag_d  = overflow_flag_q;
    invalid_flag_d   = invalid_flag_q;
    dbz_flag_d       = dbz_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          count_d = '0;
          state_d = is_special(bus.a, bus.b) ? ST_SPECIAL : ST_DIVIDE;
        end
      end

      ST_DIVIDE: begin
        if (count_q == '0) begin
          // First edge unpacks the latched operands into the datapath.
          rem_d  = {1'b0, 1'b1, frac_a};
          div_d  = {1'b1, frac_b};
          quot_d = '0;
        end else begin
          rem_d  = rem_step;
          quot_d = {quot_q[QuotWidth-2:0], rem_ge};
        end
        count_d = count_q + CountWidth'(1);
        if (count_q == CountWidth'(QuotWidth)) begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        out_d            = rnd_out;
        underflow_flag_d = rnd_uf;
        overflow_flag_d  = rnd_of;
        invalid_flag_d   = 1'b0;
        dbz_flag_d       = 1'b0;
        out_valid_d      = 1'b1;
        state_d          = ST_DONE;
      end

      ST_SPECIAL: begin
        out_d            = sp_out;
        underflow_flag_d = sp_uf;
        overflow_flag_d  = sp_of;
        invalid_flag_d   = sp_inv;
        dbz_flag_d       = sp_dbz;
        out_valid_d      = 1'b1;
        state_d          = ST_DONE;
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      in_ready_q       <= 1'b1;
      a_q              <= '0;
      b_q              <= '0;
      rem_q            <= '0;
      div_q            <= '0;
      quot_q           <= '0;
      count_q          <= '0;
      out_q            <= '0;
      out_valid_q      <= 1'b0;
      underflow_flag_q <= 1'b0;
      overflow_flag_q  <= 1'b0;
      invalid_flag_q   <= 1'b0;
      dbz_flag_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      in_ready_q       <= in_ready_d;
      a_q              <= a_d;
      b_q              <= b_d;
      rem_q            <= rem_d;
      div_q            <= div_d;
      quot_q           <= quot_d;
      count_q          <= count_d;
      out_q            <= out_d;
      out_valid_q      <= out_valid_d;
      underflow_flag_q <= underflow_flag_d;
      overflow_flag_q  <= overflow_flag_d;
      invalid_flag_q   <= invalid_flag_d;
      dbz_flag_q       <= dbz_flag_d;
    end
  end

  assign bus.in_ready               = in_ready_q;
  assign bus.out_valid              = out_valid_q;
  assign bus.out                    = out_q;
  assign bus.underflow_flag         = underflow_flag_q;
  assign bus.overflow_flag          = overflow_flag_q;
  assign bus.invalid_operation_flag = invalid_flag_q;
  assign bus.divide_by_zero_flag    = dbz_flag_q;

endmodule
